xita_reduce: RTL and testbench
==============================

XITA_REDUCE -- requirements
Module: xita_reduce

Interface
Parameters:
REQ-001 The block SHALL have parameter PI, default 205887, meaning pi in unsigned Q16.16.
REQ-002 The block SHALL have parameter WARN_TOL, default 64, meaning the LSB distance below floor(PI/2) at or above which warn asserts.
Ports:
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock, all state updates on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port start, input, 1 bit: request to reduce xita_in.
REQ-006 The block SHALL have port xita_in, input, 32 bits: signed two's-complement Q16.16 angle in radians.
REQ-007 The block SHALL have port busy, output, 1 bit: an operation is in progress.
REQ-008 The block SHALL have port valid, output, 1 bit: xita_out, neg and warn hold a completed result.
REQ-009 The block SHALL have port xita_out, output, 32 bits: reduced angle, unsigned Q16.16, range [0, floor(PI/2)].
REQ-010 The block SHALL have port neg, output, 1 bit: the downstream tangent result must be negated.
REQ-011 The block SHALL have port warn, output, 1 bit: the reduced angle is near the tangent singularity.

Function
REQ-012 Purpose: the block SHALL map any angle a to r in [0, pi/2] and a sign flag such that tan(a) = (neg ? -1 : 1) * tan(r), feeding the CORDIC tangent stage.
REQ-013 States: the block SHALL implement IDLE, ABS, REDUCE, FOLD, DONE; reset enters IDLE.
REQ-014 start SHALL be accepted only in IDLE or DONE; on the accepting edge the block SHALL latch xita_in, clear valid, set busy, and go to ABS.
REQ-015 start while busy SHALL be ignored, with no effect on state, outputs or latched operand.
REQ-016 ABS (1 cycle): the block SHALL set sign = xita_in[31] and mag = |xita_in| as 32-bit unsigned; input 0x8000_0000 SHALL give mag = 0x8000_0000 with no overflow.
REQ-017 REDUCE (14 cycles, k = 13 down to 0, one k per cycle): if mag >= PI<<k then the block SHALL set mag = mag - (PI<<k).
REQ-018 Comparisons in REDUCE SHALL use at least 36-bit width so that PI<<13 is not truncated.
REQ-019 After k = 0 the block SHALL hold r = |xita_in| mod PI, with 0 <= r < PI.
REQ-020 FOLD (1 cycle): if r > (PI>>1) the block SHALL set xita_out = PI - r and neg = ~sign; otherwise xita_out = r and neg = sign.
REQ-021 On the FOLD edge, warn SHALL be set to (xita_out >= (PI>>1) - WARN_TOL); valid SHALL be set to 1, busy cleared, and the state SHALL go to DONE.
REQ-022 Latency: with start accepted at edge 0, valid SHALL rise after edge 16 (1 ABS + 14 REDUCE + 1 FOLD).
REQ-023 xita_out, neg and warn SHALL change only on the FOLD edge and stay stable otherwise, including while busy, because the downstream stage restarts on any xita change.
REQ-024 valid SHALL stay high in DONE until the next accepted start.
REQ-025 A zero input SHALL give xita_out = 0, neg = 0, warn = 0.

Reset
REQ-026 While rst_n = 0, regardless of clk, the block SHALL force: state IDLE, busy 0, valid 0, xita_out 0, neg 0, warn 0, internal mag and k cleared.
REQ-027 A reset mid-operation SHALL abandon the operation; after release no stale result SHALL appear, and the next start SHALL begin a fresh 16-cycle operation.

Verification
REQ-028 Bench SHALL drive xita_in = 0x0001_0000 (1.0) with start -> valid after 16 edges, xita_out = 65536, neg = 0, warn = 0.
REQ-029 Bench SHALL drive xita_in = 0xFFFF_0000 (-1.0) -> xita_out = 65536, neg = 1.
REQ-030 Bench SHALL drive xita_in = 196608 (3.0) -> xita_out = 9279, neg = 1; and xita_in = 6553600 (100.0) -> xita_out = 34784, neg = 1.
REQ-031 Bench SHALL drive xita_in = 102940 -> xita_out = 102940, warn = 1; and xita_in = 0x8000_0000 -> completes with xita_out <= 102943 and no X values.
REQ-032 Bench SHALL pulse start again at edge 5 with a different xita_in -> ignored; result matches the first operand at edge 16.
REQ-033 Bench SHALL assert rst_n = 0 at edge 8 of an operation -> all outputs 0 immediately; valid does not rise after release until a new start, which then completes 16 edges later.

Source files
------------

// File: rtl/xita_reduce_if.sv
// Handshake and result bundle between the angle-reduction block and its
// requester: the requester drives start/xita_in and the reducer returns
// busy/valid plus the folded angle and its flags.
interface xita_reduce_if;
  logic               start;
  logic signed [31:0] xita_in;
  logic               busy;
  logic               valid;
  logic        [31:0] xita_out;
  logic               neg;
  logic               warn;

  modport master (
    output start, xita_in,
    input  busy, valid, xita_out, neg, warn
  );

  modport slave (
    input  start, xita_in,
    output busy, valid, xita_out, neg, warn
  );
endinterface

// File: rtl/xita_reduce.sv
// Range reduction in front of the CORDIC tangent stage.
// Maps any signed Q16.16 angle a to r in [0, PI/2] plus a negate flag so that
// tan(a) = (neg ? -1 : 1) * tan(r).
// Sequence: ABS (1 cycle), REDUCE (14 cycles of restoring division by PI,
// k = 13..0), FOLD (1 cycle), for a start-to-valid latency of 16 edges.
module xita_reduce #(
  parameter int unsigned PI       = 205887,
  parameter int unsigned WARN_TOL = 64
) (
  input  logic         clk,
  input  logic         rst_n,
  xita_reduce_if.slave bus
);

  localparam int DATA_W = 32;
  // PI<<13 needs 31 bits; 36 leaves headroom so no shifted divisor truncates.
  localparam int ACC_W  = 36;

  localparam logic [ACC_W-1:0] PI_W   = ACC_W'(PI);
  localparam logic [ACC_W-1:0] HALF_W = PI_W >> 1;
  localparam logic [ACC_W-1:0] TOL_W  = ACC_W'(WARN_TOL);
  // Guard against a tolerance larger than PI/2 so the threshold never wraps.
  localparam logic [ACC_W-1:0] WARN_THR = (TOL_W > HALF_W) ? '0 : (HALF_W - TOL_W);
  localparam logic [3:0]       K_TOP    = 4'd13;

  typedef enum logic [2:0] {
    IDLE,
    ABS,
    REDUCE,
    FOLD,
    DONE
  } state_t;

  state_t                    state;
  logic signed [DATA_W-1:0]  operand;
  logic                      sign;
  logic        [ACC_W-1:0]   mag;
  logic        [3:0]         k;

  logic                      busy_r;
  logic                      valid_r;
  logic        [DATA_W-1:0]  out_r;
  logic                      neg_r;
  logic                      warn_r;

  logic                      accept;
  logic        [DATA_W:0]    fold_res;
  logic        [DATA_W-1:0]  fold_val;
  logic                      fold_over;
  logic                      fold_warn;

  // Magnitude of a two's-complement word as unsigned; the most negative
  // value maps to 0x8000_0000, which fits the unsigned range exactly.
  function automatic logic [DATA_W-1:0] abs_mag(input logic signed [DATA_W-1:0] a);
    logic [DATA_W-1:0] u;
    u = a;
    return a[DATA_W-1] ? (~u + 1'b1) : u;
  endfunction

  // One restoring-division step: subtract PI<<k when it fits.
  function automatic logic [ACC_W-1:0] reduce_step(input logic [ACC_W-1:0] m,
                                                   input logic [3:0]       kk);
    logic [ACC_W-1:0] div;
    div = PI_W << kk;
    return (m >= div) ? (m - div) : m;
  endfunction

  // Fold r in [0, PI) onto [0, PI/2]; the top bit reports that the mirror
  // PI - r was taken, which flips the tangent sign.
  function automatic logic [DATA_W:0] fold_angle(input logic [ACC_W-1:0] r);
    logic [ACC_W-1:0] mirrored;
    if (r > HALF_W) begin
      mirrored = PI_W - r;
      return {1'b1, mirrored[DATA_W-1:0]};
    end
    return {1'b0, r[DATA_W-1:0]};
  endfunction

  // Near-singularity flag for the folded angle.
  function automatic logic warn_of(input logic [DATA_W-1:0] v);
    return (ACC_W'(v) >= WARN_THR);
  endfunction

  assign accept    = bus.start && ((state == IDLE) || (state == DONE));
  assign fold_res  = fold_angle(mag);
  assign fold_over = fold_res[DATA_W];
  assign fold_val  = fold_res[DATA_W-1:0];
  assign fold_warn = warn_of(fold_val);

  // Operand capture and sign extraction; pure datapath, no reset needed
  // because nothing downstream reads them before ABS has run.
  always_ff @(posedge clk) begin
    if (accept) begin
      operand <= bus.xita_in;
    end
    if (state == ABS) begin
      sign <= operand[DATA_W-1];
    end
  end

  // Control FSM with registered outputs; results move only on the FOLD edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      busy_r  <= 1'b0;
      valid_r <= 1'b0;
      out_r   <= '0;
      neg_r   <= 1'b0;
      warn_r  <= 1'b0;
      mag     <= '0;
      k       <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (bus.start) begin
            valid_r <= 1'b0;
            busy_r  <= 1'b1;
            state   <= ABS;
          end
        end
        ABS: begin
          mag   <= ACC_W'(abs_mag(operand));
          k     <= K_TOP;
          state <= REDUCE;
        end
        REDUCE: begin
          mag <= reduce_step(mag, k);
          if (k == 4'd0) begin
            state <= FOLD;
          end else begin
            k <= k - 4'd1;
          end
        end
        FOLD: begin
          out_r   <= fold_val;
          neg_r   <= fold_over ? ~sign : sign;
          warn_r  <= fold_warn;
          valid_r <= 1'b1;
          busy_r  <= 1'b0;
          state   <= DONE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy     = busy_r;
  assign bus.valid    = valid_r;
  assign bus.xita_out = out_r;
  assign bus.neg      = neg_r;
  assign bus.warn     = warn_r;

endmodule

// File: tb/tb_xita_reduce.sv
// Directed bench for xita_reduce: a table of operands with hand-computed
// reduced angles and flags, plus sequences for busy-start and mid-op reset.
module tb_xita_reduce;

  logic clk;
  logic rst_n;

  xita_reduce_if bus ();

  xita_reduce #(
    .PI      (205887),
    .WARN_TOL(64)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] x;
    logic [31:0] exp_out;
    logic        exp_neg;
    logic        exp_warn;
  } vec_t;

  int n_vec;
  int n_fail;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Present an operand for one edge (edge 0) and drop start afterwards.
  task automatic start_op(input logic [31:0] x);
    bus.start   = 1'b1;
    bus.xita_in = x;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
  endtask

  // Count edges until valid, noting whether the outputs moved before it.
  task automatic wait_valid(inout int lat, output bit stable);
    logic [33:0] prev;
    prev   = {bus.xita_out, bus.neg, bus.warn};
    stable = 1'b1;
    while (!bus.valid && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
      if (!bus.valid && ({bus.xita_out, bus.neg, bus.warn} !== prev)) stable = 1'b0;
    end
  endtask

  vec_t vecs[13];

  initial begin
    int lat;
    bit stable;
    logic [31:0] held;

    vecs[0]  = '{32'h0001_0000, 32'd65536,  1'b0, 1'b0};
    vecs[1]  = '{32'hFFFF_0000, 32'd65536,  1'b1, 1'b0};
    vecs[2]  = '{32'd196608,    32'd9279,   1'b1, 1'b0};
    vecs[3]  = '{32'd6553600,   32'd34784,  1'b1, 1'b0};
    vecs[4]  = '{32'd102940,    32'd102940, 1'b0, 1'b1};
    vecs[5]  = '{32'h8000_0000, 32'd82238,  1'b1, 1'b0};
    vecs[6]  = '{32'd0,         32'd0,      1'b0, 1'b0};
    vecs[7]  = '{32'd205887,    32'd0,      1'b0, 1'b0};
    vecs[8]  = '{32'd102944,    32'd102943, 1'b1, 1'b1};
    vecs[9]  = '{32'd102878,    32'd102878, 1'b0, 1'b0};
    vecs[10] = '{32'd102879,    32'd102879, 1'b0, 1'b1};
    vecs[11] = '{32'hFFFD_0000, 32'd9279,   1'b0, 1'b0};
    vecs[12] = '{32'h7FFF_FFFF, 32'd82237,  1'b0, 1'b0};

    n_vec       = 0;
    n_fail      = 0;
    rst_n       = 1'b0;
    bus.start   = 1'b0;
    bus.xita_in = '0;

    #1;
    check("reset_busy",  64'(bus.busy),     64'd0);
    check("reset_valid", 64'(bus.valid),    64'd0);
    check("reset_out",   64'(bus.xita_out), 64'd0);
    check("reset_flags", 64'({bus.neg, bus.warn}), 64'd0);

    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 13; i++) begin
      start_op(vecs[i].x);
      check($sformatf("v%0d_accept", i), 64'({bus.busy, bus.valid}), 64'b10);
      lat = 0;
      wait_valid(lat, stable);
      check($sformatf("v%0d_latency", i), 64'(lat), 64'd16);
      check($sformatf("v%0d_stable", i), 64'(stable), 64'd1);
      check($sformatf("v%0d_out", i), 64'(bus.xita_out), 64'(vecs[i].exp_out));
      check($sformatf("v%0d_neg", i), 64'(bus.neg), 64'(vecs[i].exp_neg));
      check($sformatf("v%0d_warn", i), 64'(bus.warn), 64'(vecs[i].exp_warn));
      check($sformatf("v%0d_busy", i), 64'(bus.busy), 64'd0);
      if (i == 5) begin
        check("minneg_range", 64'(bus.xita_out <= 32'd102943), 64'd1);
        check("minneg_no_x", 64'($isunknown({bus.xita_out, bus.neg, bus.warn, bus.valid})), 64'd0);
      end
      // Result must persist in DONE.
      held = bus.xita_out;
      repeat (3) @(posedge clk);
      #1;
      check($sformatf("v%0d_hold", i), 64'({bus.valid, bus.xita_out}), 64'({1'b1, held}));
    end

    // Start pulsed at edge 5 of an operation is ignored.
    start_op(32'd196608);
    lat = 0;
    repeat (4) begin
      @(posedge clk);
      #1;
      lat++;
    end
    bus.start   = 1'b1;
    bus.xita_in = 32'd6553600;
    @(posedge clk);
    #1;
    lat++;
    bus.start = 1'b0;
    check("busy_start_busy", 64'({bus.busy, bus.valid}), 64'b10);
    wait_valid(lat, stable);
    check("busy_start_latency", 64'(lat), 64'd16);
    check("busy_start_out", 64'(bus.xita_out), 64'd9279);
    check("busy_start_neg", 64'(bus.neg), 64'd1);

    // Reset during edge 8 of an operation abandons it.
    start_op(32'd6553600);
    repeat (7) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_busy",  64'(bus.busy),     64'd0);
    check("midrst_valid", 64'(bus.valid),    64'd0);
    check("midrst_out",   64'(bus.xita_out), 64'd0);
    check("midrst_flags", 64'({bus.neg, bus.warn}), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    stable = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk);
      #1;
      if (bus.valid || bus.busy) stable = 1'b0;
    end
    check("midrst_no_stale", 64'(stable), 64'd1);
    start_op(32'hFFFF_0000);
    lat = 0;
    wait_valid(lat, stable);
    check("midrst_restart_latency", 64'(lat), 64'd16);
    check("midrst_restart_out", 64'(bus.xita_out), 64'd65536);
    check("midrst_restart_neg", 64'(bus.neg), 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
